// File: rtl/mpmc11_pkg.sv
// Shared types and address-layout constants for the mpmc11 command path.
package mpmc11_pkg;

  typedef enum logic [1:0] {
    CAG_IDLE,
    CAG_ISSUE,
    CAG_DONE
  } mpmc11_cag_state_t;

  localparam int ADDR_W        = 32;
  localparam int LINE_OFS_W    = 5;
  localparam int ADDR_ZERO_MSB = 2;
  localparam int LINE_IDX_W    = ADDR_W - LINE_OFS_W - ADDR_ZERO_MSB;

endpackage

// File: rtl/mpmc11_line_inc.sv
// Combinational next-line index: linear +1 across the full index, or +1 inside a
// 2^WRAP_LG2-line window with the bits above the window held.
module mpmc11_line_inc
  import mpmc11_pkg::*;
#(
  parameter int WRAP_LG2 = 2
) (
  input  logic                  wrap_en,
  input  logic [LINE_IDX_W-1:0] cur_line,
  output logic [LINE_IDX_W-1:0] next_line
);

  localparam logic [LINE_IDX_W-1:0] WIN_MASK = LINE_IDX_W'((1 << WRAP_LG2) - 1);

  logic [LINE_IDX_W-1:0] mask;
  logic [LINE_IDX_W-1:0] inc;

  always_comb begin
    mask      = wrap_en ? WIN_MASK : '1;
    inc       = cur_line + LINE_IDX_W'(1);
    next_line = (inc & mask) | (cur_line & ~mask);
  end

endmodule

// File: rtl/mpmc11_cmd_addr_gen.sv
// Issues burst_len+1 line-spaced DRAM app commands; first app_en one cycle after start;
// app_rdy low holds the request sticky. MPMC11_CMD_WRAP_EN selects critical-line-first wrapping.
module mpmc11_cmd_addr_gen
  import mpmc11_pkg::*;
#(
  parameter logic [2:0] CMD_RD   = 3'd1,
  parameter logic [2:0] CMD_WR   = 3'd0,
  parameter int         WRAP_LG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [7:0]  burst_len,
  input  logic [31:0] addr_base,
  input  logic        app_rdy,
  output logic        app_en,
  output logic [2:0]  app_cmd,
  output logic [31:0] app_addr,
  output logic [7:0]  req_cnt,
  output logic        busy,
  output logic        done
);

  mpmc11_cag_state_t     state_q, state_d;
  logic                  app_en_d;
  logic [2:0]            app_cmd_d;
  logic [31:0]           app_addr_d;
  logic [7:0]            req_cnt_d;
  logic                  busy_d;
  logic                  done_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            len_start;
  logic                  wrap_en;
  logic                  accept;
  logic [LINE_IDX_W-1:0] next_line;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{addr_base[31:32-ADDR_ZERO_MSB], addr_base[LINE_OFS_W-1:0]};

`ifdef MPMC11_CMD_WRAP_EN
  localparam logic [7:0] LEN_MAX = 8'((1 << WRAP_LG2) - 1);
  assign wrap_en   = 1'b1;
  assign len_start = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
`else
  assign wrap_en   = 1'b0;
  assign len_start = burst_len;
`endif

  assign accept = app_en & app_rdy;

  mpmc11_line_inc #(
    .WRAP_LG2 (WRAP_LG2)
  ) u_line_inc (
    .wrap_en   (wrap_en),
    .cur_line  (app_addr[LINE_OFS_W +: LINE_IDX_W]),
    .next_line (next_line)
  );

  always_comb begin
    state_d    = state_q;
    app_en_d   = app_en;
    app_cmd_d  = app_cmd;
    app_addr_d = app_addr;
    req_cnt_d  = req_cnt;
    busy_d     = busy;
    done_d     = 1'b0;
    len_d      = len_q;
    case (state_q)
      CAG_IDLE: begin
        if (start) begin
          len_d      = len_start;
          app_cmd_d  = we ? CMD_WR : CMD_RD;
          app_addr_d = {{ADDR_ZERO_MSB{1'b0}}, addr_base[LINE_OFS_W +: LINE_IDX_W],
                        {LINE_OFS_W{1'b0}}};
          req_cnt_d  = '0;
          app_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = CAG_ISSUE;
        end
      end
      CAG_ISSUE: begin
        if (accept) begin
          req_cnt_d  = req_cnt + 8'd1;
          app_addr_d = {{ADDR_ZERO_MSB{1'b0}}, next_line, {LINE_OFS_W{1'b0}}};
          if (req_cnt == len_q) begin
            app_en_d = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = CAG_DONE;
          end
        end
      end
      CAG_DONE: state_d = CAG_IDLE;
      default:  state_d = CAG_IDLE;
    endcase
    app_addr_d[31:32-ADDR_ZERO_MSB] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CAG_IDLE;
      app_en   <= 1'b0;
      app_cmd  <= CMD_RD;
      app_addr <= '0;
      req_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      app_en   <= app_en_d;
      app_cmd  <= app_cmd_d;
      app_addr <= app_addr_d;
      req_cnt  <= req_cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_mpmc11_cmd_addr_gen.sv
// Directed and randomized bursts checked against an address-list model of the command issuer.
module tb_mpmc11_cmd_addr_gen;

  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd0;
  localparam int         WRAP_LG2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        we;
  logic [7:0]  burst_len;
  logic [31:0] addr_base;
  logic        app_rdy;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [31:0] app_addr;
  logic [7:0]  req_cnt;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  mpmc11_cmd_addr_gen #(
    .CMD_RD   (CMD_RD),
    .CMD_WR   (CMD_WR),
    .WRAP_LG2 (WRAP_LG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (we),
    .burst_len (burst_len),
    .addr_base (addr_base),
    .app_rdy   (app_rdy),
    .app_en    (app_en),
    .app_cmd   (app_cmd),
    .app_addr  (app_addr),
    .req_cnt   (req_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Address of the i-th request of a burst, straight from the line-stepping rule.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    int line;
    int win;
    line = int'(base[29:5]);
`ifdef MPMC11_CMD_WRAP_EN
    win  = 1 << WRAP_LG2;
    line = (line / win) * win + ((line % win) + i) % win;
`else
    win  = 1 << 25;
    line = (line + i) % win;
`endif
    return {2'b00, line[24:0], 5'b00000};
  endfunction

  function automatic int exp_reqs(input logic [7:0] len);
    int l;
    l = int'(len);
`ifdef MPMC11_CMD_WRAP_EN
    if (l > (1 << WRAP_LG2) - 1) l = (1 << WRAP_LG2) - 1;
`endif
    return l + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_app_en"},   32'(app_en),   32'd0);
    check({tag, "_app_cmd"},  32'(app_cmd),  32'(CMD_RD));
    check({tag, "_app_addr"}, app_addr,      32'h0);
    check({tag, "_req_cnt"},  32'(req_cnt),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  // rdy_mode: 0 always ready, 1 stall 3 cycles on the 2nd request, 2 random.
  task automatic run_burst(input logic [31:0] base, input logic [7:0] len, input logic w,
                           input int rdy_mode, input bit poke_start);
    int   n;
    int   k;
    int   cyc;
    int   stall;
    logic rdy;
    n = exp_reqs(len);
    @(negedge clk);
    start = 1'b1; addr_base = base; burst_len = len; we = w; app_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0; addr_base = $urandom; burst_len = 8'($urandom); we = 1'($urandom);
    k = 0; cyc = 0; stall = 0;
    while (k < n && cyc < 4000) begin
      check("issue_app_en",   32'(app_en),  32'd1);
      check("issue_app_addr", app_addr,     exp_addr(base, k));
      check("issue_app_cmd",  32'(app_cmd), 32'(w ? CMD_WR : CMD_RD));
      check("issue_req_cnt",  32'(req_cnt), 32'(k[7:0]));
      check("issue_busy",     32'(busy),    32'd1);
      check("issue_done",     32'(done),    32'd0);
      start = poke_start && (cyc == 0);
      if (rdy_mode == 1 && k == 1 && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else if (rdy_mode == 2) begin
        rdy = ($urandom_range(0, 9) < 6);
      end else begin
        rdy = 1'b1;
      end
      app_rdy = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    check("burst_accepts", 32'(k), 32'(n));
    start = 1'b1; app_rdy = 1'($urandom);
    check("done_pulse",   32'(done),    32'd1);
    check("done_app_en",  32'(app_en),  32'd0);
    check("done_busy",    32'(busy),    32'd0);
    check("done_req_cnt", 32'(req_cnt), 32'(n[7:0]));
    @(negedge clk);
    start = 1'b0;
    check("post_done_pulse",  32'(done),   32'd0);
    check("post_done_app_en", 32'(app_en), 32'd0);
    check("post_done_busy",   32'(busy),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; burst_len = '0; addr_base = '0; app_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_burst(32'h0000_1234, 8'd3, 1'b0, 0, 1'b0);
    run_burst(32'h0000_1234, 8'd3, 1'b0, 1, 1'b0);
    run_burst($urandom, 8'd0, 1'b1, 0, 1'b0);
    run_burst(32'hFFFF_FFE0, 8'd1, 1'b0, 0, 1'b0);
    run_burst($urandom, 8'd5, 1'b1, 2, 1'b1);

    // Reset in the middle of a burst, with a start on the same edge.
    @(negedge clk);
    start = 1'b1; addr_base = $urandom; burst_len = 8'd20; we = 1'b1; app_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0; app_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_start_ignored");
    run_burst(32'h0000_4000, 8'd2, 1'b0, 0, 1'b0);

    run_burst(32'h0000_1060, 8'd3, 1'b0, 0, 1'b0);
    run_burst($urandom, 8'd255, 1'b0, 0, 1'b0);

    for (int b = 0; b < 15; b++) begin
      run_burst($urandom, 8'($urandom_range(0, 40)), 1'($urandom), 2, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
